// File: rtl/board_state_arbiter.sv
// board_state_arbiter: 12x12 cell-state memory with a free-running pixel read port
// and a round-robin shared write path that sequences clear, write and fire operations.
module board_state_arbiter #(
    parameter int GRID_CELLS = 12,
    parameter int COORD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   rd_col,
    input  logic [COORD_W-1:0]   rd_row,
    output logic [1:0]           rd_data,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic [1:0]           req,
    input  logic [1:0]           op,
    input  logic [2*COORD_W-1:0] col,
    input  logic [2*COORD_W-1:0] row,
    input  logic [3:0]           wdata,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [1:0]           result,
    output logic                 err
);
    localparam int DEPTH = GRID_CELLS * GRID_CELLS;
    localparam int AW = 2 * COORD_W;
    typedef enum logic [2:0] {CLEAR, IDLE, WR, RMW_RD, RMW_WR} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic ptr_q, ptr_d, sel_q, sel_d, op_q, op_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [1:0] wdata_q, wdata_d, old_q, old_d;
    logic [1:0] gnt_q, gnt_d, done_q, done_d, result_q, result_d, rd_data_q;
    logic err_q, err_d;
    logic [1:0] mem_q [DEPTH];
    logic [AW-1:0] addr, rd_addr, waddr;
    logic ok, rd_ok, we, sel;
    logic [1:0] wval;

    assign addr    = AW'(row_q) * AW'(GRID_CELLS) + AW'(col_q);
    assign ok      = (int'(col_q) < GRID_CELLS) && (int'(row_q) < GRID_CELLS);
    assign rd_addr = AW'(rd_row) * AW'(GRID_CELLS) + AW'(rd_col);
    assign rd_ok   = (int'(rd_col) < GRID_CELLS) && (int'(rd_row) < GRID_CELLS);
    // on a tie the requester that did not win last time goes next
    assign sel     = (req == 2'b11) ? ~ptr_q : req[1];
    assign busy    = state_q != IDLE;
    // a reset arriving mid-operation suppresses the pending write
    assign we      = !rst && (state_q == CLEAR || ((state_q == WR || state_q == RMW_WR) && ok));
    assign waddr   = (state_q == CLEAR) ? cnt_q : addr;
    assign wval    = (state_q == CLEAR) ? 2'b00 : (state_q == WR) ? wdata_q : {1'b1, old_q[0]};

    assign rd_data = rd_data_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign result  = result_q;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wval;
        sel_q   <= sel_d;
        op_q    <= op_d;
        col_q   <= col_d;
        row_q   <= row_d;
        wdata_q <= wdata_d;
        old_q   <= old_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            ptr_q     <= 1'b1;
            gnt_q     <= '0;
            done_q    <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            err_q     <= err_d;
            rd_data_q <= rd_ok ? mem_q[rd_addr] : 2'b00;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        op_d     = op_q;
        col_d    = col_q;
        row_d    = row_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        gnt_d    = '0;
        done_d   = '0;
        result_d = '0;
        err_d    = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (|req) begin
                    sel_d      = sel;
                    ptr_d      = sel;
                    op_d       = op[sel];
                    col_d      = col[sel*COORD_W +: COORD_W];
                    row_d      = row[sel*COORD_W +: COORD_W];
                    wdata_d    = wdata[sel*2 +: 2];
                    gnt_d[sel] = 1'b1;
                    state_d    = op[sel] ? RMW_RD : WR;
                end
            end
            WR: begin
                done_d[sel_q] = 1'b1;
                result_d      = ok ? wdata_q : 2'b00;
                err_d         = !ok;
                state_d       = IDLE;
            end
            RMW_RD: begin
                old_d   = ok ? mem_q[addr] : 2'b00;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                done_d[sel_q] = 1'b1;
                result_d      = old_q;
                err_d         = !ok;
                state_d       = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end
endmodule

// File: tb/tb_board_state_arbiter.sv
// tb_board_state_arbiter: directed and randomized checks of board_state_arbiter
// against a cell-array model of the board.
module tb_board_state_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] rd_col, rd_row;
    logic [1:0] rd_data;
    logic clr_req, busy;
    logic [1:0] req, op, gnt, done, result;
    logic [7:0] col, row;
    logic [3:0] wdata;
    logic err;
    int checks = 0;
    int failures = 0;
    logic [1:0] model [144];
    logic [1:0] fire_map [4] = '{2'b10, 2'b11, 2'b10, 2'b11};

    board_state_arbiter dut (
        .clk(clk), .rst(rst), .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data),
        .clr_req(clr_req), .busy(busy), .req(req), .op(op), .col(col), .row(row),
        .wdata(wdata), .gnt(gnt), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 144; k++) model[k] = 2'b00;
    endtask

    task automatic busy_len();
        int n = 0;
        while (busy && n < 300) begin
            n++;
            tick();
        end
        chk("busy_len", n, 144);
    endtask

    task automatic rd(input int r, input int c);
        rd_row = 4'(r);
        rd_col = 4'(c);
        tick();
        chk("rd_data", rd_data, (r < 12 && c < 12) ? model[r*12+c] : 2'b00);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < 400);
    endtask

    task automatic do_op(input int i, input logic o, input int c, input int r,
                         input logic [1:0] wd, input int lat);
        int n;
        logic bad;
        logic [1:0] exp_res;
        req[i] = 1'b1;
        op[i] = o;
        col[i*4 +: 4] = 4'(c);
        row[i*4 +: 4] = 4'(r);
        wdata[i*2 +: 2] = wd;
        wait_gnt(n);
        chk("gnt", gnt, 2'b01 << i);
        if (lat > 0) chk("gnt_lat", n, lat);
        req[i] = 1'b0;
        bad = (c >= 12) || (r >= 12);
        exp_res = bad ? 2'b00 : (o ? model[r*12+c] : wd);
        if (o) begin
            tick();
            chk("done_early", done, 2'b00);
        end
        tick();
        chk("done", done, 2'b01 << i);
        chk("result", result, exp_res);
        chk("err", err, bad);
        if (!bad) model[r*12+c] = o ? fire_map[model[r*12+c]] : wd;
    endtask

    initial begin
        int n;
        int exp_i;
        rst = 1'b1; clr_req = 1'b0; req = '0; op = '0; col = '0; row = '0;
        wdata = '0; rd_col = '0; rd_row = '0;
        clear_model();
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        busy_len();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++) rd(r, c);
        rd(12, 0);

        // tie right after reset goes to 0, then grants alternate
        req = 2'b11; op = 2'b00;
        col = {4'd2, 4'd1}; row = 8'h00; wdata = {2'b10, 2'b01};
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            exp_i = k % 2;
            chk("alt_gnt", gnt, 2'b01 << exp_i);
            model[exp_i + 1] = exp_i ? 2'b10 : 2'b01;
        end
        req = 2'b00;
        tick();
        chk("alt_done", done, 2'b10);
        rd(0, 1);
        rd(0, 2);

        do_op(0, 1'b0, 3, 5, 2'b01, 1);
        rd(5, 3);
        do_op(1, 1'b1, 3, 5, 2'b00, 1);
        rd(5, 3);
        do_op(1, 1'b1, 3, 5, 2'b00, 1);
        rd(5, 3);
        do_op(0, 1'b1, 0, 0, 2'b00, 1);
        rd(0, 0);
        do_op(0, 1'b0, 12, 5, 2'b11, 1);
        rd(5, 0);
        rd(6, 0);

        // clear wins over a simultaneous request; request is served afterwards
        req[0] = 1'b1; op[0] = 1'b0; col[3:0] = 4'd2; row[3:0] = 4'd2; wdata[1:0] = 2'b01;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        clear_model();
        busy_len();
        do_op(0, 1'b0, 2, 2, 2'b01, 0);
        rd(5, 3);
        rd(2, 2);

        for (int k = 0; k < 40; k++)
            do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
                  2'($urandom_range(0, 3)), 1);
        for (int k = 0; k < 20; k++) rd(int'($urandom_range(0, 13)), int'($urandom_range(0, 13)));

        // reset during the write cycle of a fire
        do_op(0, 1'b0, 1, 1, 2'b01, 1);
        req[0] = 1'b1; op[0] = 1'b1; col[3:0] = 4'd1; row[3:0] = 4'd1;
        wait_gnt(n);
        chk("rmw_gnt", gnt, 2'b01);
        req[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_done", done, 0);
        chk("rst_mid_busy", busy, 1);
        rst = 1'b0;
        clear_model();
        busy_len();
        rd(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/board_state_arbiter.md
Name: board_state_arbiter

Overview:
- Owns the cell-state memory of one 12x12 game board. Each cell is drawn by the grid overlay as a 32-pixel square.
- Serves a dedicated, always-available read port to the pixel pipeline, which maps hcount/vcount to a cell.
- Shares a single write path between two requesters (0: local ship placement, 1: remote shot reports) using round-robin arbitration.
- Sequences board clear and atomic "fire" read-modify-write operations.

Parameters:
- GRID_CELLS, 12, cells per row/column; memory depth is GRID_CELLS*GRID_CELLS, address = row*GRID_CELLS+col.
- COORD_W, 4, width of a column/row index.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rd_col  in  COORD_W  pixel-pipeline read column
- rd_row  in  COORD_W  pixel-pipeline read row
- rd_data  out  2  cell state: 00 empty, 01 ship, 10 miss, 11 hit
- clr_req  in  1  single-cycle pulse requesting a board clear
- busy  out  1  high whenever the FSM is not IDLE
- req  in  2  write request, bit i belongs to requester i
- op  in  2  per requester: 0 = write, 1 = fire
- col  in  2*COORD_W  per-requester column; requester i uses slice [i*COORD_W +: COORD_W]
- row  in  2*COORD_W  per-requester row, same slicing as col
- wdata  in  4  per-requester write value, [2i+:2]; used only for op=0
- gnt  out  2  one-cycle acceptance pulse
- done  out  2  one-cycle completion pulse
- result  out  2  valid while any done bit is high
- err  out  1  pulses together with done when the coordinate is out of range

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rd_data=0, gnt=0, done=0, result=0, err=0, last-grant pointer=1 (requester 0 wins the first tie). State resets to CLEAR, so busy=1 during and after reset.
- Read port:
  - Independent of the FSM, latency 1: rd_data is registered from (rd_row, rd_col) sampled the previous cycle.
  - Read-before-write: a read of a cell being written this cycle returns the old value.
  - Out-of-range address (rd_col or rd_row >= GRID_CELLS) reads 00.
- FSM states: CLEAR, IDLE, WR, RMW_RD, RMW_WR.
- CLEAR:
  - A counter runs from 0 to GRID_CELLS^2-1 (143 by default), writing 00 to one cell per cycle.
  - After the last cell the FSM goes to IDLE, so busy stays high for exactly 144 cycles after rst deasserts.
  - clr_req and req are ignored while in CLEAR; pending requests are served once IDLE is reached.
- IDLE (cycle T):
  - clr_req has priority: go to CLEAR, counter=0.
  - Otherwise, if any req bit is set, select requester i:
    - only one requesting: that one;
    - both requesting: the one not equal to the last-grant pointer.
  - On selection: latch col/row/op/wdata of i, update the pointer to i, drive gnt[i]=1 in T+1, next state WR (op=0) or RMW_RD (op=1).
- Requester contract: hold req and its fields stable until gnt is seen, then drop req in that same cycle. Because the FSM leaves IDLE, req is not re-sampled until the operation completes.
- WR (T+1): write wdata to the cell. done[i]=1 and result=wdata appear in T+2; then IDLE.
- RMW_RD (T+1): capture the old cell value.
- RMW_WR (T+2): write the new value using the mapping 00->10, 01->11, 10->10, 11->11. done[i]=1 and result=old value appear in T+3; then IDLE.
- Out-of-range coordinate (col or row >= GRID_CELLS) on either op: no write, result=00, err=1. done/err are delivered in the same cycle a valid op would deliver them.
- Throughput:
  - Write: a new acceptance is possible in T+2.
  - Fire: a new acceptance is possible in T+3.
- gnt, done and err are single-cycle pulses and never overlap between requesters.
- rst asserted in any state, including mid-RMW: the pending write is not performed, no done is issued, and the FSM enters CLEAR.

Test Plan:
- Release rst -> busy=1 for exactly 144 cycles, then 0. Sweeping all 144 (row,col) reads rd_data=00; reading (12,0) gives 00.
- Requester 0 write at col=3, row=5, wdata=01 (req at T) -> gnt[0] at T+1; done[0]=1, result=01 at T+2. rd_col=3, rd_row=5 then gives rd_data=01 one cycle later.
- Fire sequence:
  - requester 1 fires at (3,5) -> done[1] at T+3, result=01, cell then reads 11;
  - firing again at (3,5) -> result=11, cell stays 11;
  - firing at empty (0,0) -> result=00, cell reads 10.
- Both requesters hold req continuously with alternating writes -> grants go 0,1,0,1. A tie right after reset goes to requester 0.
- clr_req in the same cycle as req[0] in IDLE -> clear wins: busy high for 144 cycles, then gnt[0]; previously written cells read 00.
- Error and reset cases:
  - requester 0 write at col=12 -> done[0] and err at T+2, no cell changed;
  - rst asserted at T+2 of a fire at (1,1) holding 01 -> no done, busy high, cell reads 00 after the clear.
